// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the per-entry record of the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  // One in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [REG_W-1:0]  rd;
    logic              is_branch;
    logic              mispredict;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_bypass_read.sv
// Operand lookup by ROB id with bypass from the writeback broadcast.
module rob_bypass_read
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH_BIT = ROB_W
) (
  input  logic [ROB_WIDTH_BIT-1:0]      id,
  input  logic [(1<<ROB_WIDTH_BIT)-1:0] avail,
  input  logic [DATA_W-1:0]             value [1<<ROB_WIDTH_BIT],
  input  logic                          cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0]      cdb_rob_id,
  input  logic [DATA_W-1:0]             cdb_val,
  input  logic                          block,
  output logic                          ready,
  output logic [DATA_W-1:0]             val
);

  logic hit;

  // A same-cycle broadcast wins over the stored value; the issuing tail never reads ready.
  always_comb begin
    hit   = cdb_valid && (cdb_rob_id == id);
    ready = !block && (avail[id] || hit);
    val   = '0;
    if (ready) begin
      val = hit ? cdb_val : value[id];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue: rename update, commit write-back, operand queries, branch flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH_BIT = ROB_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic                     issue_is_branch,
  output logic                     full,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic [REG_W-1:0]         new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [DATA_W-1:0]        cdb_val,
  input  logic                     cdb_mispredict,
  input  logic [DATA_W-1:0]        cdb_target,
  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [DATA_W-1:0]        rs1_val,
  output logic [DATA_W-1:0]        rs2_val,
  output logic                     commit_valid,
  output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  output logic [REG_W-1:0]         write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [DATA_W-1:0]        write_val,
  output logic                     clear_flag,
  output logic [DATA_W-1:0]        redirect_pc
);

  localparam int unsigned W     = ROB_WIDTH_BIT;
  localparam int unsigned DEPTH = 1 << W;

  rob_entry_t     ent_q [DEPTH];
  logic [W-1:0]   head_q, tail_q;
  logic [W:0]     count_q;

  rob_entry_t        head_ent;
  logic              issue_acc;
  logic              flush;
  logic [DEPTH-1:0]  avail;
  logic [DATA_W-1:0] value_arr [DEPTH];

  // Handshake decode for issue, commit and branch flush.
  always_comb begin
    head_ent     = ent_q[head_q];
    full         = (count_q == (W+1)'(DEPTH));
    issue_acc    = issue_valid && rdy_in && !full && !clear_flag;
    commit_valid = rdy_in && !clear_flag && (count_q != '0) && head_ent.ready;
    flush        = commit_valid && head_ent.is_branch && head_ent.mispredict;
  end

  // Rename and commit buses are zero unless the transfer actually happens.
  always_comb begin
    issue_rob_id  = tail_q;
    new_reg_id    = issue_acc ? issue_rd : '0;
    new_ROB_id    = issue_acc ? tail_q : '0;
    commit_rob_id = head_q;
    write_reg_id  = commit_valid ? head_ent.rd : '0;
    write_ROB_id  = commit_valid ? head_q : '0;
    write_val     = commit_valid ? head_ent.value : '0;
  end

  // Flatten entries into what the query ports need.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      avail[W'(i)]     = ent_q[W'(i)].valid && ent_q[W'(i)].ready;
      value_arr[W'(i)] = ent_q[W'(i)].value;
    end
  end

  rob_bypass_read #(.ROB_WIDTH_BIT(W)) u_rs1 (
    .id(rs1_id), .avail(avail), .value(value_arr),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .block(issue_acc && (rs1_id == tail_q)),
    .ready(rs1_ready), .val(rs1_val)
  );

  rob_bypass_read #(.ROB_WIDTH_BIT(W)) u_rs2 (
    .id(rs2_id), .avail(avail), .value(value_arr),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .block(issue_acc && (rs2_id == tail_q)),
    .ready(rs2_ready), .val(rs2_val)
  );

  // Entry storage, pointers and flush pulse; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      clear_flag  <= 1'b0;
      redirect_pc <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[W'(i)] <= '0;
      end
    end else if (rdy_in) begin
      clear_flag <= flush;
      if (flush) begin
        redirect_pc <= head_ent.target;
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
          ent_q[W'(i)].valid <= 1'b0;
        end
      end else begin
        if (cdb_valid && ent_q[cdb_rob_id].valid) begin
          ent_q[cdb_rob_id].ready      <= 1'b1;
          ent_q[cdb_rob_id].value      <= cdb_val;
          ent_q[cdb_rob_id].mispredict <= cdb_mispredict;
          ent_q[cdb_rob_id].target     <= cdb_target;
        end
        if (issue_acc) begin
          ent_q[tail_q].valid      <= 1'b1;
          ent_q[tail_q].ready      <= 1'b0;
          ent_q[tail_q].mispredict <= 1'b0;
          ent_q[tail_q].rd         <= issue_rd;
          ent_q[tail_q].is_branch  <= issue_is_branch;
          tail_q                   <= tail_q + W'(1);
        end
        if (commit_valid) begin
          ent_q[head_q].valid <= 1'b0;
          head_q              <= head_q + W'(1);
        end
        case ({issue_acc, commit_valid})
          2'b10:   count_q <= count_q + (W+1)'(1);
          2'b01:   count_q <= count_q - (W+1)'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order commit queue for the out-of-order core. Producer/consumer end of the register-file rename interface.
- Drives the rename update (new_reg_id/new_ROB_id) and the commit write-back (write_reg_id/write_ROB_id/write_val).
- Answers operand-readiness queries by ROB id, with CDB bypass.
- Raises clear_flag after a mispredicted branch commits.

Parameters:
ROB_WIDTH_BIT, 3, ROB index width; DEPTH = 1<<ROB_WIDTH_BIT entries (8)

Ports:
clk_in  in  1  system clock, single domain
rst_in  in  1  asynchronous, active-low reset (0 = reset)
rdy_in  in  1  low: freeze all state, accept nothing
issue_valid  in  1  decoder issues one instruction this cycle
issue_rd  in  5  destination register, 0 = no register write
issue_is_branch  in  1  entry resolves a branch
full  out  1  count==DEPTH; issue is refused
issue_rob_id  out  W  tail index; id the issuing instruction receives
new_reg_id  out  5  issue_rd if issue accepted, else 0
new_ROB_id  out  W  tail if issue accepted, else 0
cdb_valid  in  1  writeback broadcast
cdb_rob_id  in  W  entry being written
cdb_val  in  32  result value
cdb_mispredict  in  1  branch resolved opposite to prediction
cdb_target  in  32  correct next PC for the branch
rs1_id / rs2_id  in  W  query ids
rs1_ready / rs2_ready  out  1  queried entry has a value available
rs1_val / rs2_val  out  32  that value, else 0
commit_valid  out  1  head retires at this edge
commit_rob_id  out  W  head index
write_reg_id  out  5  head rd when commit_valid, else 0
write_ROB_id  out  W  head index when commit_valid, else 0
write_val  out  32  head value when commit_valid, else 0
clear_flag  out  1  registered one-cycle flush pulse
redirect_pc  out  32  registered; valid while clear_flag is high

Behaviour:
- Storage per entry:
  - valid, ready, rd[4:0], is_branch, mispredict, value[31:0], target[31:0].
  - Pointers head, tail (W bits, natural wrap DEPTH-1→0); count (W+1 bits).
- Reset (rst_in low, asynchronous):
  - head=tail=count=0; all valid=0; clear_flag=0; redirect_pc=0.
  - Consequently full=0 and every combinational output is 0.
- Stall: rdy_in low → no register changes.
  - new_reg_id, new_ROB_id and commit outputs are forced to 0.
  - Query outputs stay live.
- Issue accepted when issue_valid & rdy_in & !full & !clear_flag.
  - At the edge: entry[tail] gets valid=1, ready=0, mispredict=0, rd, is_branch; tail+1.
  - new_* outputs are combinational in the same cycle.
- Writeback: cdb_valid & entry valid → at the edge, value/mispredict/target are written and ready=1.
  - A CDB hit on an invalid entry is ignored.
- Commit:
  - commit_valid = rdy_in & !clear_flag & count!=0 & entry[head].ready.
  - Commit outputs are combinational from head; the register file samples them at the same edge.
  - On that edge: valid[head]=0, head+1.
  - Earliest commit is the cycle after the CDB write (no same-cycle CDB→commit).
- Mispredict: a committing head with is_branch & mispredict still emits its rd write. At that edge:
  - clear_flag<=1 and redirect_pc<=target.
  - head=tail=count=0 and all valid cleared; a same-cycle issue is discarded.
  - Next cycle: clear_flag=1, no issue, no commit. The following cycle clear_flag<=0.
- clear_flag otherwise deasserts after exactly one cycle.
- Count update:
  - issue only → +1; commit only → −1; both → unchanged.
  - full uses the pre-edge count; issue is refused even if a commit frees a slot this cycle.
- Query (per port, combinational):
  - ready = (valid & ready) | (cdb_valid & cdb_rob_id==id).
  - val = CDB value on a bypass hit, else the stored value; 0 when not ready.
  - The tail id while issuing returns ready=0.

Decomposition:
- const.v: ROB_WIDTH_BIT and ROB_SIZE defines; entry field widths.
- One sub-module is natural: rob_bypass_read, a combinational lookup plus CDB bypass, instantiated twice (rs1, rs2).

Test Plan:
- Reset:
  - Hold rst_in=0 mid-run with 3 entries live, then release.
  - Required: count=0, full=0, clear_flag=0, all commit outputs 0, issue_rob_id=0.
- Out-of-order writeback:
  - Issue rd=5,6,7 (ids 0,1,2); CDB id2=0x33, then id0=0x11, then id1=0x22.
  - Required: commits in order 5←0x11, 6←0x22, 7←0x33; id2 does not commit before id1.
- Full and wrap:
  - Issue 8 with no writeback → full=1; a 9th issue produces new_reg_id=0.
  - Commit one and issue one → new_ROB_id=0 (wrapped).
- Bypass:
  - rs1_id=3 with cdb_valid, cdb_rob_id=3, cdb_val=0xABCD in the same cycle → rs1_ready=1, rs1_val=0xABCD.
  - Querying the invalid id 7 → ready=0, val=0.
- Mispredict:
  - Branch id0 rd=1 written with mispredict=1, target=0x100; id1,id2 pending.
  - Required: commit write_reg_id=1; next cycle clear_flag=1, redirect_pc=0x100, count=0; the cycle after, clear_flag=0.
- Stall:
  - rdy_in=0 for 4 cycles with a ready head and issue_valid=1.
  - Required: no commit, no issue, pointers unchanged; resumes on the first cycle with rdy_in=1.
